// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl
// Description : Branch predictor for the IF stage with a bimodal history
//               table trained from ID-stage outcomes; raises flush/redirect
//               on mispredict. Optional stats counters with BPU_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int BHT_ENTRIES = 16,
    parameter int INDEX_LSB   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Strategy,
    input  logic [31:0] if_pc,
    input  logic        if_is_branch,
    input  logic [31:0] if_target,
    input  logic        if_stall,
    output logic        predict_taken,
    output logic [31:0] predict_pc,
    input  logic        id_valid,
    input  logic        id_branch,
    input  logic [31:0] id_pc,
    input  logic        id_taken,
    input  logic [31:0] id_target,
    output logic        flush_if,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef BPU_STATS_EN
    ,
    output logic [31:0] pred_count,
    output logic [31:0] mispred_count
`endif
);

    localparam int         c_IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [1:0] c_STRAT_TAKEN = 2'b01;
    localparam logic [1:0] c_STRAT_BIMOD = 2'b10;

    logic [1:0]         bht_q [BHT_ENTRIES];
    logic [1:0]         bht_d [BHT_ENTRIES];
    logic               pred_q;
    logic               pred_v_q;
    logic [c_IDX_W-1:0] w_if_idx;
    logic [c_IDX_W-1:0] w_id_idx;
    logic [1:0]         w_cur;
    logic               w_p;
    logic               w_resolve;
    logic               w_mispredict;
    logic               w_unused_pc;

    assign w_if_idx    = if_pc[INDEX_LSB +: c_IDX_W];
    assign w_id_idx    = id_pc[INDEX_LSB +: c_IDX_W];
    assign w_unused_pc = ^{if_pc, id_pc};

    always_comb begin
        w_p = 1'b0;
        case (Strategy)
            c_STRAT_TAKEN: w_p = 1'b1;
            c_STRAT_BIMOD: w_p = bht_q[w_if_idx][1];
            default:       w_p = 1'b0;
        endcase
    end

    assign predict_taken = if_is_branch & w_p;
    assign predict_pc    = predict_taken ? if_target : (if_pc + 32'd4);

    assign w_resolve    = id_valid & id_branch;
    assign w_mispredict = w_resolve & (id_taken != (pred_q & pred_v_q));

    assign flush_if       = w_mispredict;
    assign redirect_valid = w_mispredict;
    assign redirect_pc    = w_mispredict ? (id_taken ? id_target : (id_pc + 32'd4))
                                         : 32'd0;

    // Saturating 2-bit counter update; IF reads bht_q, so no same-cycle bypass
    always_comb begin
        bht_d = bht_q;
        w_cur = bht_q[w_id_idx];
        if (w_resolve) begin
            if (id_taken) begin
                if (w_cur != 2'b11) bht_d[w_id_idx] = w_cur + 2'd1;
            end else begin
                if (w_cur != 2'b00) bht_d[w_id_idx] = w_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end

    // A flush kills the fetched instruction even while IF/ID is stalled
    always_ff @(posedge clk) begin
        if (reset || flush_if) begin
            pred_q   <= 1'b0;
            pred_v_q <= 1'b0;
        end else if (!if_stall) begin
            pred_q   <= predict_taken;
            pred_v_q <= if_is_branch;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] pred_count_q;
    logic [31:0] mispred_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_count_q    <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            if (w_resolve)    pred_count_q    <= pred_count_q + 32'd1;
            if (w_mispredict) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign pred_count    = pred_count_q;
    assign mispred_count = mispred_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_ctrl
// Description : Directed self-checking bench for branch_predict_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Strategy;
    logic [31:0] if_pc;
    logic        if_is_branch;
    logic [31:0] if_target;
    logic        if_stall;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic        id_valid;
    logic        id_branch;
    logic [31:0] id_pc;
    logic        id_taken;
    logic [31:0] id_target;
    logic        flush_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BPU_STATS_EN
    logic [31:0] pred_count;
    logic [31:0] mispred_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_predict_ctrl #(.BHT_ENTRIES(16), .INDEX_LSB(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .Strategy       (Strategy),
        .if_pc          (if_pc),
        .if_is_branch   (if_is_branch),
        .if_target      (if_target),
        .if_stall       (if_stall),
        .predict_taken  (predict_taken),
        .predict_pc     (predict_pc),
        .id_valid       (id_valid),
        .id_branch      (id_branch),
        .id_pc          (id_pc),
        .id_taken       (id_taken),
        .id_target      (id_target),
        .flush_if       (flush_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BPU_STATS_EN
        ,
        .pred_count     (pred_count),
        .mispred_count  (mispred_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_if(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
        if_pc        = pc;
        if_is_branch = br;
        if_target    = tgt;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        id_valid  = v;
        id_branch = v;
        id_pc     = pc;
        id_taken  = tk;
        id_target = tgt;
    endtask

    task automatic idle();
        drive_if(32'h0000_0200, 1'b0, 32'h0);
        drive_id(1'b0, 32'h0, 1'b0, 32'h0);
        if_stall = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        drive_if(32'h0000_0100, 1'b0, 32'h0);
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL rst_pt: got %0h want 0", predict_taken); end
        checks++; if (predict_pc !== 32'h104) begin errors++; $display("FAIL rst_ppc: got %h want 00000104", predict_pc); end
        checks++; if (flush_if !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_flush: got %0h/%0h want 0/0", flush_if, redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_rpc: got %h want 00000000", redirect_pc); end
`ifdef BPU_STATS_EN
        checks++; if (pred_count !== 32'd0 || mispred_count !== 32'd0) begin errors++; $display("FAIL rst_stats: got %0d/%0d want 0/0", pred_count, mispred_count); end
`endif
        tick();
    endtask

    task automatic test_static_not_taken();
        Strategy = 2'b00;
        drive_if(32'h10, 1'b1, 32'h1C);
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL snt_pt: got %0h want 0", predict_taken); end
        checks++; if (predict_pc !== 32'h14) begin errors++; $display("FAIL snt_ppc: got %h want 00000014", predict_pc); end
        tick();
        idle();
        drive_id(1'b1, 32'h10, 1'b1, 32'h1C);
        #1;
        checks++; if (flush_if !== 1'b1 || redirect_valid !== 1'b1) begin errors++; $display("FAIL snt_flush: got %0h/%0h want 1/1", flush_if, redirect_valid); end
        checks++; if (redirect_pc !== 32'h1C) begin errors++; $display("FAIL snt_rpc: got %h want 0000001c", redirect_pc); end
        tick();
        idle();
        #1;
        checks++; if (flush_if !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL snt_one_cycle: got %0h/%h want 0/00000000", flush_if, redirect_pc); end
    endtask

    task automatic test_static_taken();
        Strategy = 2'b01;
        drive_if(32'h10, 1'b1, 32'h1C);
        #1;
        checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL st_pt: got %0h want 1", predict_taken); end
        checks++; if (predict_pc !== 32'h1C) begin errors++; $display("FAIL st_ppc: got %h want 0000001c", predict_pc); end
        tick();
        idle();
        drive_id(1'b1, 32'h10, 1'b0, 32'h1C);
        #1;
        checks++; if (flush_if !== 1'b1) begin errors++; $display("FAIL st_flush: got %0h want 1", flush_if); end
        checks++; if (redirect_pc !== 32'h14) begin errors++; $display("FAIL st_rpc: got %h want 00000014", redirect_pc); end
        tick();
        idle();
        #1;
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL st_one_cycle: got %0h want 0", redirect_valid); end
    endtask

    task automatic test_bimodal();
        Strategy = 2'b10;
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b0 || predict_pc !== 32'h34) begin errors++; $display("FAIL bim_f1: got %0h/%h want 0/00000034", predict_taken, predict_pc); end
        tick();
        idle();
        drive_id(1'b1, 32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (flush_if !== 1'b1 || redirect_pc !== 32'h60) begin errors++; $display("FAIL bim_r1: got %0h/%h want 1/00000060", flush_if, redirect_pc); end
        tick();
        idle();
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b1 || predict_pc !== 32'h60) begin errors++; $display("FAIL bim_f2: got %0h/%h want 1/00000060", predict_taken, predict_pc); end
        tick();
        idle();
        drive_id(1'b1, 32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL bim_r2: got %0h want 0", flush_if); end
        tick();
        idle();
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL bim_f3: got %0h want 1", predict_taken); end
        tick();
        idle();
        drive_id(1'b1, 32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (flush_if !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL bim_r3: got %0h/%0h want 0/0", flush_if, redirect_valid); end
        tick();
        idle();
    endtask

    task automatic test_saturate();
        Strategy = 2'b10;
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL sat_start: got %0h want 1", predict_taken); end
        idle();
        for (int n = 0; n < 5; n++) begin
            drive_id(1'b1, 32'h30, 1'b0, 32'h60);
            #1;
            checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL sat_nt%0d: got %0h want 0", n, flush_if); end
            tick();
        end
        idle();
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL sat_floor: got %0h want 0", predict_taken); end
        idle();
        drive_id(1'b1, 32'h30, 1'b1, 32'h60);
        tick();
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL sat_nobypass: got %0h want 0", predict_taken); end
        tick();
        idle();
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL sat_visible: got %0h want 1", predict_taken); end
        idle();
        tick();
    endtask

    task automatic test_stall();
        Strategy = 2'b01;
        drive_if(32'h40, 1'b1, 32'h80);
        tick();
        idle();
        if_stall = 1'b1;
        drive_if(32'h44, 1'b0, 32'h0);
        repeat (3) tick();
        if_stall = 1'b0;
        idle();
        drive_id(1'b1, 32'h40, 1'b1, 32'h80);
        #1;
        checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL stall_hold: got %0h want 0", flush_if); end
        tick();
        idle();
        drive_if(32'h50, 1'b1, 32'h90);
        tick();
        idle();
        if_stall = 1'b1;
        drive_if(32'h54, 1'b1, 32'h94);
        drive_id(1'b1, 32'h50, 1'b0, 32'h90);
        #1;
        checks++; if (flush_if !== 1'b1 || redirect_pc !== 32'h54) begin errors++; $display("FAIL stall_flush: got %0h/%h want 1/00000054", flush_if, redirect_pc); end
        tick();
        idle();
        drive_id(1'b1, 32'h54, 1'b1, 32'h94);
        #1;
        checks++; if (flush_if !== 1'b1 || redirect_pc !== 32'h94) begin errors++; $display("FAIL stall_cleared: got %0h/%h want 1/00000094", flush_if, redirect_pc); end
        tick();
        idle();
    endtask

    task automatic test_pc_wrap();
        Strategy = 2'b01;
        drive_if(32'hFFFF_FFFC, 1'b0, 32'h100);
        #1;
        checks++; if (predict_pc !== 32'h0) begin errors++; $display("FAIL wrap_ppc: got %h want 00000000", predict_pc); end
        drive_if(32'hFFFF_FFFC, 1'b1, 32'h100);
        #1;
        checks++; if (predict_pc !== 32'h100) begin errors++; $display("FAIL wrap_tgt: got %h want 00000100", predict_pc); end
        tick();
        idle();
        drive_id(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h100);
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin errors++; $display("FAIL wrap_rpc: got %0h/%h want 1/00000000", redirect_valid, redirect_pc); end
        tick();
        idle();
    endtask

    task automatic test_reset_midrun();
        Strategy = 2'b01;
        drive_if(32'h10, 1'b1, 32'h1C);
        tick();
        drive_if(32'h20, 1'b1, 32'h70);
        drive_id(1'b1, 32'h10, 1'b0, 32'h1C);
        reset = 1'b1;
        #1;
        checks++; if (flush_if !== 1'b1 || redirect_pc !== 32'h14) begin errors++; $display("FAIL rmid_pending: got %0h/%h want 1/00000014", flush_if, redirect_pc); end
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++; if (flush_if !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL rmid_out: got %0h/%0h/%h want 0/0/00000000", flush_if, redirect_valid, redirect_pc); end
`ifdef BPU_STATS_EN
        checks++; if (pred_count !== 32'd0 || mispred_count !== 32'd0) begin errors++; $display("FAIL rmid_stats: got %0d/%0d want 0/0", pred_count, mispred_count); end
`endif
        drive_id(1'b1, 32'h20, 1'b0, 32'h70);
        #1;
        checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL rmid_predclr: got %0h want 0", flush_if); end
        tick();
        idle();
        Strategy = 2'b10;
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL rmid_bht30: got %0h want 0", predict_taken); end
        drive_if(32'h00, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL rmid_bht00: got %0h want 0", predict_taken); end
        drive_if(32'h14, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b0) begin errors++; $display("FAIL rmid_bht14: got %0h want 0", predict_taken); end
        idle();
        drive_id(1'b1, 32'h30, 1'b1, 32'h60);
        tick();
        idle();
        drive_if(32'h30, 1'b1, 32'h60);
        #1;
        checks++; if (predict_taken !== 1'b1) begin errors++; $display("FAIL rmid_bht01: got %0h want 1", predict_taken); end
        idle();
        tick();
    endtask

`ifdef BPU_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (pred_count !== 32'd0 || mispred_count !== 32'd0) begin errors++; $display("FAIL stats_zero: got %0d/%0d want 0/0", pred_count, mispred_count); end
        Strategy = 2'b00;
        drive_id(1'b1, 32'h100, 1'b0, 32'h0); tick();
        drive_id(1'b1, 32'h104, 1'b0, 32'h0); tick();
        drive_id(1'b1, 32'h108, 1'b1, 32'h0); tick();
        drive_id(1'b1, 32'h10C, 1'b0, 32'h0); tick();
        idle();
        #1;
        checks++; if (pred_count !== 32'd4 || mispred_count !== 32'd1) begin errors++; $display("FAIL stats_count: got %0d/%0d want 4/1", pred_count, mispred_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (pred_count !== 32'd0 || mispred_count !== 32'd0) begin errors++; $display("FAIL stats_clear: got %0d/%0d want 0/0", pred_count, mispred_count); end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        Strategy = 2'b00;
        idle();
        test_reset();
        test_static_not_taken();
        test_static_taken();
        test_bimodal();
        test_saturate();
        test_stall();
        test_pc_wrap();
        test_reset_midrun();
`ifdef BPU_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
